// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: 32-bit signed multi-cycle multiply (shift-add) and divide (restoring).
// Every operation has the same 34-cycle start-to-done latency. busy stalls the pipeline.
module mult_div_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic [31:0] port_a,
  input  logic [31:0] port_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic        div_zero_q, div_zero_d;

  logic        accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_signed;
  logic [31:0] quo_signed, rem_signed;

  always_comb begin
    accept      = start && !flush && ((state_q == IDLE) || (state_q == DONE));
    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    abs_a       = port_a[31] ? -port_a : port_a;
    abs_b       = port_b[31] ? -port_b : port_b;
    mul_sum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mag_a_q} : 33'd0);
    div_shift   = {rem_q, quo_q[31]};
    div_diff    = div_shift - {1'b0, mag_b_q};
    prod_signed = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_signed  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_signed  = sign_a_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    prod_d     = prod_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            state_d    = CALC;
            count_d    = 5'd0;
            op_d       = op;
            sign_a_d   = port_a[31];
            sign_b_d   = port_b[31];
            mag_a_d    = abs_a;
            mag_b_d    = abs_b;
            prod_d     = {32'd0, abs_b};
            quo_d      = abs_a;
            rem_d      = 32'd0;
            div_zero_d = 1'b0;
          end
        end
        CALC: begin
          count_d = count_q + 5'd1;
          if (op_q[1]) begin
            // A zero divisor always "fits", giving an all-ones quotient and rem = |a|.
            if (div_shift >= {1'b0, mag_b_q}) begin
              rem_d = div_diff[31:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = div_shift[31:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
          end else begin
            prod_d = {mul_sum, prod_q[31:1]};
          end
          if (count_q == 5'd31) begin
            state_d = FIX;
          end
        end
        FIX: begin
          state_d    = DONE;
          div_zero_d = op_q[1] && (mag_b_q == 32'd0);
          case (op_q)
            OP_MUL:  result_d = prod_signed[31:0];
            OP_MULH: result_d = prod_signed[63:32];
            OP_DIV:  result_d = (mag_b_q == 32'd0) ? 32'hFFFF_FFFF : quo_signed;
            default: result_d = rem_signed;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      op_q       <= 2'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mag_a_q    <= 32'd0;
      mag_b_q    <= 32'd0;
      prod_q     <= 64'd0;
      quo_q      <= 32'd0;
      rem_q      <= 32'd0;
      result_q   <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      prod_q     <= prod_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire
